// File: rtl/seq_pattern_tx.sv
// seq_pattern_tx: serial pattern transmitter. Shifts a latched PAT_W-bit
// pattern out MSB-first, repeated 'reps' times with 'gap' zero bits between
// repetitions, then pulses 'done' for one cycle.
// Optional overlapping self-check matcher: define SEQ_PATTERN_TX_SELFCHECK_EN.
module seq_pattern_tx #(
  parameter int PAT_W = 4,
  parameter int CNT_W = 8,
  parameter int GAP_W = 4
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  input  logic [PAT_W-1:0] pattern,
  input  logic [CNT_W-1:0] reps,
  input  logic [GAP_W-1:0] gap,
  output logic             ready,
  output logic             busy,
  output logic             x,
  output logic             x_valid,
  output logic             done,
  output logic [CNT_W-1:0] match_cnt
);

  localparam int IDX_W = (PAT_W > 1) ? $clog2(PAT_W) : 1;
  localparam logic [IDX_W-1:0] IDX_MAX = IDX_W'(PAT_W - 1);

  typedef enum logic [1:0] {IDLE, SEND, GAP, DONE} state_t;

  state_t           state_q, state_d;
  logic [PAT_W-1:0] pat_q, pat_d;
  logic [GAP_W-1:0] gap_q, gap_d;
  logic [CNT_W-1:0] rep_left_q, rep_left_d;
  logic [IDX_W-1:0] bit_idx_q, bit_idx_d;
  logic [GAP_W-1:0] gap_cnt_q, gap_cnt_d;
  logic             start_acc;

  // A start only counts while idle; anything else is dropped, not queued.
  assign start_acc = (state_q == IDLE) && start;

  // All outputs decode from registered state, never from inputs.
  assign ready   = (state_q == IDLE);
  assign busy    = (state_q == SEND) || (state_q == GAP);
  assign x_valid = busy;
  assign x       = (state_q == SEND) && pat_q[bit_idx_q];
  assign done    = (state_q == DONE);

  // Next-state and counter updates for the transmit sequencer.
  always_comb begin
    state_d    = state_q;
    pat_d      = pat_q;
    gap_d      = gap_q;
    rep_left_d = rep_left_q;
    bit_idx_d  = bit_idx_q;
    gap_cnt_d  = gap_cnt_q;
    case (state_q)
      IDLE: begin
        if (start) begin
          pat_d = pattern;
          gap_d = gap;
          if (reps == '0) begin
            state_d = DONE;
          end else begin
            bit_idx_d  = IDX_MAX;
            rep_left_d = reps;
            state_d    = SEND;
          end
        end
      end
      SEND: begin
        if (bit_idx_q == '0) begin
          if (rep_left_q == CNT_W'(1)) begin
            state_d = DONE;
          end else begin
            rep_left_d = rep_left_q - 1'b1;
            if (gap_q == '0) begin
              bit_idx_d = IDX_MAX;
            end else begin
              gap_cnt_d = gap_q;
              state_d   = GAP;
            end
          end
        end else begin
          bit_idx_d = bit_idx_q - 1'b1;
        end
      end
      GAP: begin
        gap_cnt_d = gap_cnt_q - 1'b1;
        if (gap_cnt_q == GAP_W'(1)) begin
          bit_idx_d = IDX_MAX;
          state_d   = SEND;
        end
      end
      DONE: begin
        state_d = IDLE;
      end
      default: begin
        state_d = IDLE;
      end
    endcase
  end

  // Sequencer state and shadow registers.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q    <= IDLE;
      pat_q      <= '0;
      gap_q      <= '0;
      rep_left_q <= '0;
      bit_idx_q  <= '0;
      gap_cnt_q  <= '0;
    end else begin
      state_q    <= state_d;
      pat_q      <= pat_d;
      gap_q      <= gap_d;
      rep_left_q <= rep_left_d;
      bit_idx_q  <= bit_idx_d;
      gap_cnt_q  <= gap_cnt_d;
    end
  end

`ifdef SEQ_PATTERN_TX_SELFCHECK_EN
  localparam int FILL_W = $clog2(PAT_W + 1);
  localparam logic [FILL_W-1:0] FILL_MAX  = FILL_W'(PAT_W);
  localparam logic [FILL_W-1:0] FILL_LAST = FILL_W'(PAT_W - 1);

  logic [PAT_W-1:0]  win_q, win_d, win_next;
  logic [FILL_W-1:0] fill_q, fill_d;
  logic [CNT_W-1:0]  match_q, match_d;

  assign match_cnt = match_q;

  // Overlapping matcher on the line stream; the fill count keeps stale
  // window contents from matching before a full pattern has been sent.
  always_comb begin
    win_d    = win_q;
    fill_d   = fill_q;
    match_d  = match_q;
    win_next = {win_q[PAT_W-2:0], x};
    if (start_acc) begin
      win_d   = '0;
      fill_d  = '0;
      match_d = '0;
    end else if (x_valid) begin
      win_d = win_next;
      if (fill_q != FILL_MAX) begin
        fill_d = fill_q + 1'b1;
      end
      if ((win_next == pat_q) && (fill_q >= FILL_LAST) && (match_q != '1)) begin
        match_d = match_q + 1'b1;
      end
    end
  end

  // Matcher registers.
  always_ff @(posedge clk) begin
    if (rst) begin
      win_q   <= '0;
      fill_q  <= '0;
      match_q <= '0;
    end else begin
      win_q   <= win_d;
      fill_q  <= fill_d;
      match_q <= match_d;
    end
  end
`else
  assign match_cnt = '0;
`endif

endmodule

// File: tb/tb_seq_pattern_tx.sv
// Testbench for seq_pattern_tx: directed and random transfers checked
// bit-by-bit against a queue-based reference of the expected line stream.
module tb_seq_pattern_tx;

  localparam int PAT_W = 4;
  localparam int CNT_W = 8;
  localparam int GAP_W = 4;

  logic             clk = 1'b0;
  logic             rst;
  logic             start;
  logic [PAT_W-1:0] pattern;
  logic [CNT_W-1:0] reps;
  logic [GAP_W-1:0] gap;
  logic             ready, busy, x, x_valid, done;
  logic [CNT_W-1:0] match_cnt;

  int total_cnt = 0;
  int pass_cnt  = 0;

  seq_pattern_tx #(.PAT_W(PAT_W), .CNT_W(CNT_W), .GAP_W(GAP_W)) dut (
    .clk(clk), .rst(rst), .start(start), .pattern(pattern), .reps(reps),
    .gap(gap), .ready(ready), .busy(busy), .x(x), .x_valid(x_valid),
    .done(done), .match_cnt(match_cnt)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total_cnt++;
    assert (obs === exp) begin
      pass_cnt++;
    end else begin
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // Reference: expected bit stream and overlapping match count.
  task automatic model(input logic [PAT_W-1:0] p, input int r, input int g,
                       output bit q[$], output int m);
    logic [PAT_W-1:0] w;
    q = {};
    for (int k = 0; k < r; k++) begin
      for (int b = PAT_W - 1; b >= 0; b--) q.push_back(p[b]);
      if (k < r - 1) for (int z = 0; z < g; z++) q.push_back(1'b0);
    end
    m = 0;
    w = '0;
    for (int i = 0; i < q.size(); i++) begin
      w = {w[PAT_W-2:0], q[i]};
      if (i >= PAT_W - 1 && w == p && m < (1 << CNT_W) - 1) m++;
    end
`ifndef SEQ_PATTERN_TX_SELFCHECK_EN
    m = 0;
`endif
  endtask

  // Called at a negedge with ready expected high; returns at a negedge
  // where ready is high again, so back-to-back calls test start on ready.
  task automatic xfer(input logic [PAT_W-1:0] p, input int r, input int g, input bit poke);
    bit q[$];
    int m;
    int bad;
    model(p, r, g, q, m);
    chk("ready_before_start", ready, 1'b1);
    start = 1'b1; pattern = p; reps = CNT_W'(r); gap = GAP_W'(g);
    @(posedge clk); #1;
    start = 1'b0; pattern = $urandom; reps = $urandom; gap = $urandom;
    bad = 0;
    for (int i = 0; i < q.size(); i++) begin
      @(negedge clk);
      if (x_valid !== 1'b1 || x !== q[i] || done !== 1'b0 || ready !== 1'b0) begin
        bad++;
        chk($sformatf("bit%0d_x_valid_x_done_ready", i), {x_valid, x, done, ready},
            {1'b1, q[i], 1'b0, 1'b0});
      end
      if (poke && i == 1) begin
        start = 1'b1; pattern = ~p; reps = 8'd3; gap = 4'd0;
        @(posedge clk); #1;
        start = 1'b0;
      end
    end
    chk("stream_bits_ok", bad, 0);
    @(negedge clk);
    chk("done_pulse", {done, x_valid, x, busy}, 4'b1000);
    chk("match_cnt", match_cnt, m);
    @(negedge clk);
    chk("done_cleared", done, 1'b0);
    $display("xfer pat=%b reps=%0d gap=%0d bits=%0d match=%0d", p, r, g, q.size(), m);
  endtask

  initial begin
    rst = 1'b1; start = 1'b0; pattern = '0; reps = '0; gap = '0;
    repeat (2) @(posedge clk);
    #1 rst = 1'b0;
    @(negedge clk);
    chk("reset_outputs", {ready, busy, x, x_valid, done, match_cnt},
        {1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 8'd0});

    // Reset mid-idle for two cycles.
    rst = 1'b1;
    repeat (2) @(posedge clk);
    #1 rst = 1'b0;
    @(negedge clk);
    chk("idle_reset_outputs", {ready, busy, x, x_valid, done, match_cnt},
        {1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 8'd0});

    // Test-plan directed transfers.
    xfer(4'b1010, 1, 0, 1'b0);
    xfer(4'b1010, 2, 0, 1'b0);
    xfer(4'b1011, 2, 2, 1'b0);
    xfer(4'b1101, 0, 5, 1'b0);
    xfer(4'b1001, 3, 1, 1'b1);
    xfer(4'b1111, 3, 0, 1'b0);

    // Reset during SEND aborts without a done pulse.
    start = 1'b1; pattern = 4'b1100; reps = 8'd4; gap = 4'd1;
    @(posedge clk); #1 start = 1'b0;
    repeat (2) @(negedge clk);
    chk("pre_abort_busy", busy, 1'b1);
    rst = 1'b1;
    @(posedge clk); #1;
    @(negedge clk);
    chk("abort_outputs", {ready, busy, x_valid, done, match_cnt},
        {1'b1, 1'b0, 1'b0, 1'b0, 8'd0});
    rst = 1'b0;
    begin
      int seen = 0;
      for (int i = 0; i < 30; i++) begin
        @(negedge clk);
        if (done === 1'b1 || x_valid === 1'b1) seen++;
      end
      chk("no_done_after_abort", seen, 0);
    end

    // Maximum repeat count and gap.
    xfer(4'b0110, 255, 15, 1'b0);

    // Random transfers.
    for (int t = 0; t < 25; t++) begin
      xfer(PAT_W'($urandom), int'($urandom_range(0, 6)), int'($urandom_range(0, 4)),
           bit'($urandom_range(0, 1)));
    end

    $display("%0d/%0d checks passed", pass_cnt, total_cnt);
    $finish;
  end

endmodule

// File: doc/seq_pattern_tx.md
# seq_pattern_tx

Serial pattern transmitter that drives the single-bit `x` stream consumed by the overlapping Mealy sequence detectors. It accepts a `PAT_W`-bit pattern, repeat count and inter-repetition gap through a start/ready handshake. It shifts the pattern out MSB-first, one bit per clock, and reports completion with a one-cycle `done` pulse. Its purpose is to supply deterministic, repeatable stimulus for detector blocks and to act as the transmit end of the serial-pattern link.

## Interface
- `PAT_W`, 4: pattern width in bits (≥2).
- `CNT_W`, 8: width of repeat count and match counter.
- `GAP_W`, 4: width of the gap length, in idle bit-times.

- `clk`  in  1  clock; all logic on rising edge.
- `rst`  in  1  synchronous, active-high reset.
- `start`  in  1  request; accepted only when `ready`=1.
- `pattern`  in  `PAT_W`  bits to send; MSB is transmitted first.
- `reps`  in  `CNT_W`  number of pattern repetitions; 0 means none.
- `gap`  in  `GAP_W`  zero bits inserted between repetitions; 0 means back-to-back.
- `ready`  out  1  high only in IDLE.
- `busy`  out  1  high in SEND and GAP.
- `x`  out  1  serial bit.
- `x_valid`  out  1  `x` is a stream bit this cycle.
- `done`  out  1  one-cycle completion pulse.
- `match_cnt`  out  `CNT_W`  self-check count (see Configuration).

## Operation
- FSM states: IDLE, SEND, GAP, DONE. All state is held in registers. Outputs are decoded from registers only, with no combinational path from inputs.
- Reset values: state IDLE, `x`=0, `x_valid`=0, `done`=0, `busy`=0, `ready`=1, `match_cnt`=0. All internal counters and shadow registers are 0.
- IDLE, `start`=1:
  - Latch `pattern`, `reps` and `gap` into shadow registers. Later input changes have no effect.
  - If `reps`=0, go to DONE.
  - Otherwise set `bit_idx`=`PAT_W`-1 and `rep_left`=`reps`, then go to SEND.
- SEND:
  - `x`=`pat[bit_idx]`, `x_valid`=1. `bit_idx` decrements each cycle.
  - When `bit_idx`=0: if `rep_left`=1, go to DONE.
  - Otherwise decrement `rep_left`. If `gap`=0, reload `bit_idx` and stay in SEND. If `gap`>0, load `gap_cnt`=`gap` and go to GAP.
- GAP:
  - `x`=0, `x_valid`=1. Gap bits are part of the line stream.
  - `gap_cnt` decrements. When `gap_cnt`=1, reload `bit_idx`=`PAT_W`-1 and go to SEND.
- DONE: `done`=1, `x_valid`=0, `x`=0. Always go to IDLE on the next edge.
- `start` while not IDLE is ignored. It is not queued.
- `rst` during any state aborts the transfer. After the reset edge all outputs take their reset values; no `done` pulse is produced for the aborted transfer.

## Timing
- `start` sampled high in IDLE at edge N: first bit (pattern MSB) appears with `x_valid`=1 in the cycle after edge N.
- Valid-bit cycles per transfer: `reps`·`PAT_W` + (`reps`−1)·`gap`. These cycles are contiguous, with no bubbles.
- `done` is high in the cycle immediately after the last valid bit. `ready` returns in the following cycle.
- `reps`=0: `done` is high in the cycle after the start edge, and `x_valid` never rises.
- Minimum start-to-start spacing is valid-bit cycles + 2.
- `rep_left` and `gap_cnt` never wrap. Maximum `reps` (all ones) and maximum `gap` must complete correctly.

## Configuration
- Macro: `SEQ_PATTERN_TX_SELFCHECK_EN`.
- When defined, an overlapping matcher runs on the emitted stream:
  - On each edge where `x_valid`=1, `win_next` = {`win[PAT_W-2:0]`, `x`}.
  - If `win_next` equals the latched pattern and at least `PAT_W` valid bits have been sent since start, `match_cnt` increments, saturating at all-ones.
  - `win`, the fill count and `match_cnt` clear on start acceptance.
  - `match_cnt` is final during the `done` cycle and holds until the next accepted start or reset.
- When undefined, the matcher logic is absent and `match_cnt` is tied to 0.

## Test plan
- Assert `rst` for 2 cycles mid-idle, then check reset values: `ready`=1, all other outputs 0. Repeat with `rst` asserted during SEND: `x_valid`=0 and `ready`=1 after the reset edge, and no `done` pulse.
- `pattern`=4'b1010, `reps`=1, `gap`=0 → `x`=1,0,1,0 with `x_valid`=1 for 4 cycles, then `done` for 1 cycle. `match_cnt`=1 (self-check builds).
- `pattern`=1010, `reps`=2, `gap`=0 → `x`=10101010 over 8 contiguous cycles, then `done`. `match_cnt`=3, from the overlapping matches.
- `pattern`=1011, `reps`=2, `gap`=2 → `x`=1011 00 1011 over 10 valid cycles, then `done`. `match_cnt`=2.
- `reps`=0 → `done` in the cycle after start, `x_valid` never high, `match_cnt`=0.
- Pulse `start` with a different pattern during SEND → the stream is unchanged and only one `done` is produced. A `start` issued in the cycle `ready` returns high is accepted.
